axi_filter_range_ctrl: RTL

Run-time configuration controller for the AXI address-range filter. It holds shadow copies of the START/STOP range registers and applies them to the filter atomically. To apply, it gates new AW/AR acceptance, tracks outstanding write and read transactions until both reach zero, copies shadow to active, then releases the gates. It sits beside the filter, drives its START_ADDR/STOP_ADDR inputs, and observes filter-side handshakes.

---
 rtl/axi_filter_range_ctrl_if.sv | 47 ++++
 rtl/axi_filter_range_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/axi_filter_range_ctrl_if.sv
// Configuration, status and filter-side handshake bundle for axi_filter_range_ctrl.
interface axi_filter_range_ctrl_if #(
    parameter int unsigned AXI_ADDR_WIDTH      = 32,
    parameter int unsigned NBR_RANGE           = 1,
    parameter int unsigned NBR_OUTSTANDING_REQ = 4
);
    localparam int unsigned IDX_WIDTH = (NBR_RANGE > 1) ? $clog2(NBR_RANGE) : 1;
    localparam int unsigned CW        = $clog2(NBR_OUTSTANDING_REQ + 1);

    logic                                       cfg_valid_i;
    logic                                       cfg_ready_o;
    logic [IDX_WIDTH-1:0]                       cfg_idx_i;
    logic [AXI_ADDR_WIDTH-1:0]                  cfg_start_i;
    logic [AXI_ADDR_WIDTH-1:0]                  cfg_stop_i;
    logic                                       commit_i;
    logic                                       busy_o;
    logic                                       done_o;
    logic                                       timeout_o;
    logic                                       cfg_err_o;
    logic                                       cnt_err_o;
    logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0]   START_ADDR_o;
    logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0]   STOP_ADDR_o;
    logic                                       aw_gate_o;
    logic                                       ar_gate_o;
    logic                                       aw_hs_i;
    logic                                       b_hs_i;
    logic                                       ar_hs_i;
    logic                                       r_last_hs_i;
    logic [CW-1:0]                              wr_outstanding_o;
    logic [CW-1:0]                              rd_outstanding_o;

    modport master (
        output cfg_valid_i, cfg_idx_i, cfg_start_i, cfg_stop_i, commit_i,
               aw_hs_i, b_hs_i, ar_hs_i, r_last_hs_i,
        input  cfg_ready_o, busy_o, done_o, timeout_o, cfg_err_o, cnt_err_o,
               START_ADDR_o, STOP_ADDR_o, aw_gate_o, ar_gate_o,
               wr_outstanding_o, rd_outstanding_o
    );

    modport slave (
        input  cfg_valid_i, cfg_idx_i, cfg_start_i, cfg_stop_i, commit_i,
               aw_hs_i, b_hs_i, ar_hs_i, r_last_hs_i,
        output cfg_ready_o, busy_o, done_o, timeout_o, cfg_err_o, cnt_err_o,
               START_ADDR_o, STOP_ADDR_o, aw_gate_o, ar_gate_o,
               wr_outstanding_o, rd_outstanding_o
    );
endinterface

// File: rtl/axi_filter_range_ctrl.sv
// Atomic range update for the AXI address filter: gate AW/AR, drain outstanding
// transactions, copy shadow ranges to active, release the gates.
module axi_filter_range_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH      = 32,
    parameter int unsigned NBR_RANGE           = 1,
    parameter int unsigned NBR_OUTSTANDING_REQ = 4,
    parameter int unsigned DRAIN_TIMEOUT       = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    axi_filter_range_ctrl_if.slave bus
);
    localparam int unsigned IDX_WIDTH = (NBR_RANGE > 1) ? $clog2(NBR_RANGE) : 1;
    localparam int unsigned CW        = $clog2(NBR_OUTSTANDING_REQ + 1);
    localparam int unsigned TW        = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int unsigned TO_LAST   = (DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GATE  = 2'd1,
        S_DRAIN = 2'd2,
        S_APPLY = 2'd3
    } state_t;

    state_t                                   r_state;
    state_t                                   w_state_nxt;
    logic [TW-1:0]                            r_drain_cnt;
    logic [CW-1:0]                            r_wr_cnt;
    logic [CW-1:0]                            r_rd_cnt;
    logic [CW-1:0]                            w_wr_nxt;
    logic [CW-1:0]                            w_rd_nxt;
    logic                                     w_wr_err;
    logic                                     w_rd_err;
    logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0] r_shadow_start;
    logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0] r_shadow_stop;
    logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0] r_active_start;
    logic [NBR_RANGE-1:0][AXI_ADDR_WIDTH-1:0] r_active_stop;
    logic                                     r_cfg_ready;
    logic                                     r_busy;
    logic                                     r_done;
    logic                                     r_timeout;
    logic                                     r_cfg_err;
    logic                                     r_cnt_err;
    logic                                     w_done_nxt;
    logic                                     w_timeout_nxt;
    logic                                     w_drained;
    logic                                     w_cfg_acc;
    logic                                     w_idx_bad;
    logic [IDX_WIDTH-1:0]                     w_idx;

    // Saturating outstanding counter; MSB of the result flags under/overflow.
    function automatic logic [CW:0] cnt_step(input logic [CW-1:0] cnt,
                                             input logic          inc,
                                             input logic          dec);
        logic [CW:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            if (cnt == CW'(NBR_OUTSTANDING_REQ)) res[CW] = 1'b1;
            else                                  res = {1'b0, cnt + CW'(1)};
        end else if (dec && !inc) begin
            if (cnt == '0) res[CW] = 1'b1;
            else           res = {1'b0, cnt - CW'(1)};
        end
        return res;
    endfunction

    assign {w_wr_err, w_wr_nxt} = cnt_step(r_wr_cnt, bus.aw_hs_i, bus.b_hs_i);
    assign {w_rd_err, w_rd_nxt} = cnt_step(r_rd_cnt, bus.ar_hs_i, bus.r_last_hs_i);

    assign w_drained = (r_wr_cnt == '0) && (r_rd_cnt == '0);
    assign w_idx     = bus.cfg_idx_i;
    assign w_idx_bad = 32'(w_idx) >= NBR_RANGE;
    assign w_cfg_acc = bus.cfg_valid_i && r_cfg_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.commit_i) w_state_nxt = S_GATE;
            S_GATE:  w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = S_APPLY;
                end else if ((DRAIN_TIMEOUT != 0) && (r_drain_cnt == TW'(TO_LAST))) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_APPLY: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state != S_DRAIN)) r_drain_cnt <= '0;
        else                               r_drain_cnt <= r_drain_cnt + TW'(1);
    end

    // Status and flags are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_cnt_err      <= 1'b0;
            r_cfg_err      <= 1'b0;
            r_cfg_ready    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_shadow_start <= '0;
            r_shadow_stop  <= '0;
            r_active_start <= '0;
            r_active_stop  <= '0;
        end else begin
            r_wr_cnt    <= w_wr_nxt;
            r_rd_cnt    <= w_rd_nxt;
            r_cnt_err   <= r_cnt_err | w_wr_err | w_rd_err;
            r_cfg_ready <= (w_state_nxt != S_APPLY);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
            if (w_cfg_acc) begin
                if (w_idx_bad) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    for (int unsigned i = 0; i < NBR_RANGE; i++) begin
                        if (32'(w_idx) == i) begin
                            r_shadow_start[i] <= bus.cfg_start_i;
                            r_shadow_stop[i]  <= bus.cfg_stop_i;
                        end
                    end
                end
            end
            if (r_state == S_APPLY) begin
                r_active_start <= r_shadow_start;
                r_active_stop  <= r_shadow_stop;
            end
        end
    end

    assign bus.cfg_ready_o      = r_cfg_ready;
    assign bus.busy_o           = r_busy;
    assign bus.aw_gate_o        = r_busy;
    assign bus.ar_gate_o        = r_busy;
    assign bus.done_o           = r_done;
    assign bus.timeout_o        = r_timeout;
    assign bus.cfg_err_o        = r_cfg_err;
    assign bus.cnt_err_o        = r_cnt_err;
    assign bus.START_ADDR_o     = r_active_start;
    assign bus.STOP_ADDR_o      = r_active_stop;
    assign bus.wr_outstanding_o = r_wr_cnt;
    assign bus.rd_outstanding_o = r_rd_cnt;
endmodule
